reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Two-port round-robin arbiter that owns an 8-entry x 16-bit register bank (RAM8-style storage built from load-enabled registers).
- Shares that bank between two requesters, A and B, each using a valid/ready request channel and a one-cycle response pulse.
- Sequences every access as accept followed by respond, so at most one load hits the bank per transaction.
- Sits between the bank and two clients, for example a CPU data port and a debug/loader port.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers in the bank.
- AW, 3, address width (log2 DEPTH).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid_a  in  1  A requests an access.
- req_we_a  in  1  A access type: 1 = write, 0 = read.
- req_addr_a  in  AW  A register index.
- req_wdata_a  in  WIDTH  A write data.
- req_ready_a  out  1  A request accepted this cycle.
- rsp_valid_a  out  1  A response pulse.
- rsp_rdata_a  out  WIDTH  A response data.
- req_valid_b, req_we_b, req_addr_b, req_wdata_b, req_ready_b, rsp_valid_b, rsp_rdata_b: same as the A ports, for requester B.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE.
  - All DEPTH registers = 0.
  - last_grant = B, so A wins the first contention.
  - rsp_valid_a = rsp_valid_b = 0.
  - rsp_rdata_a = rsp_rdata_b = 0.
  - Reset takes priority over any accept or response in that same cycle.
- req_ready_x is combinational: state == IDLE AND req_valid_x AND grant == x.
  - It is never high in RESP.
  - At most one req_ready is high in any cycle.
- Grant selection in IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - Neither valid: no grant, stay in IDLE.
- Accept edge (valid & ready in IDLE):
  - Latch the winner id, we, addr and wdata.
  - Set last_grant to the winner.
  - Go to RESP.
  - Write: reg[addr] <= wdata on this same edge.
  - Read: capture reg[addr] into the response register on this same edge.
- RESP state (exactly one cycle):
  - Winner's rsp_valid = 1.
  - Winner's rsp_rdata = captured read data, or the written data for a write.
  - The other requester's rsp_valid = 0.
  - Next state is IDLE unconditionally.
- Latency and throughput:
  - Request accepted at edge N; response visible in cycle N+1.
  - Next accept possible at edge N+2, giving at most one transaction per 2 cycles.
- rsp_rdata_x holds its last value when rsp_valid_x = 0 and changes only on that requester's response.
- Requester obligations: hold valid, we, addr and wdata stable until ready. Dropping valid before ready is legal and simply withdraws the request; the arbiter keeps no memory of it.
- Fairness: under continuous contention grants strictly alternate A, B, A, B. The worst-case wait is one other transaction (2 cycles).
- Data width: data is stored and returned verbatim, with no sign or width conversion. Full 16-bit patterns 0x0000 to 0xFFFF must round-trip.
- Read after write to the same address by the other requester, in the next transaction, returns the new value.
- Unused addresses never change.
- Reset mid-operation: rst_n low during RESP suppresses that response (rsp_valid = 0 from the reset edge) and clears the bank and last_grant. Any write already committed is lost.
- No combinational path from req_* to rsp_*.

Test Plan:
- Post-reset read: hold rst_n = 0 for 2 cycles then release; A reads addr 5 -> req_ready_a high in the first IDLE cycle, rsp_valid_a high next cycle with rsp_rdata_a = 0x0000, rsp_valid_b stays 0.
- Cross-port coherence: A writes 0x8285 (-32123) to addr 3, then B reads addr 3 -> rsp_rdata_b = 0x8285; a read of addr 2 returns 0x0000.
- Simultaneous first contention after reset: A writes addr 1 = 1 and B writes addr 1 = 2, both valid in the same cycle -> A accepted first, B accepted 2 cycles later; a subsequent read of addr 1 returns 2.
- Sustained contention: both keep valid high for 4 reads each -> accept order A, B, A, B, A, B, A, B, one accept every 2 cycles, each rsp_valid exactly 1 cycle wide, never both high together.
- Walking-ones plus MSB: write 1<<k to addr k for k = 0..6 and 0x8000 to addr 7, then read all 8 -> each returns exactly its written value.
- Reset mid-op: A write addr 4 = 0x1234 accepted, rst_n = 0 during the RESP cycle -> rsp_valid_a = 0 after the edge; after release, read addr 4 = 0x0000; on the next contention A wins first.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that shares an 8 x 16 register bank between requesters A and B.
// Each access takes one accept cycle and then one response cycle.
module reg_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_a,
  input  logic             req_we_a,
  input  logic [AW-1:0]    req_addr_a,
  input  logic [WIDTH-1:0] req_wdata_a,
  output logic             req_ready_a,
  output logic             rsp_valid_a,
  output logic [WIDTH-1:0] rsp_rdata_a,
  input  logic             req_valid_b,
  input  logic             req_we_b,
  input  logic [AW-1:0]    req_addr_b,
  input  logic [WIDTH-1:0] req_wdata_b,
  output logic             req_ready_b,
  output logic             rsp_valid_b,
  output logic [WIDTH-1:0] rsp_rdata_b
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_b_q;
  logic             win_b_q;
  logic [WIDTH-1:0] rsp_rdata_a_q, rsp_rdata_b_q;
  logic [WIDTH-1:0] bank_q [DEPTH];

  logic             grant_b;
  logic             accept;
  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic [WIDTH-1:0] acc_data;
  logic [DEPTH-1:0] bank_we;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // B wins only when A is absent or A held the previous grant.
  always_comb begin
    grant_b     = 1'b0;
    req_ready_a = 1'b0;
    req_ready_b = 1'b0;
    rsp_valid_a = 1'b0;
    rsp_valid_b = 1'b0;
    case (state_q)
      IDLE: begin
        grant_b     = req_valid_b & (~req_valid_a | ~last_b_q);
        req_ready_a = req_valid_a & ~grant_b;
        req_ready_b = req_valid_b & grant_b;
      end
      RESP: begin
        rsp_valid_a = ~win_b_q;
        rsp_valid_b = win_b_q;
      end
      default: ;
    endcase
  end

  assign accept    = req_ready_a | req_ready_b;
  assign acc_we    = grant_b ? req_we_b    : req_we_a;
  assign acc_addr  = grant_b ? req_addr_b  : req_addr_a;
  assign acc_wdata = grant_b ? req_wdata_b : req_wdata_a;
  // Writes echo the written value back as response data.
  assign acc_data  = acc_we ? acc_wdata : bank_q[acc_addr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank_we
    assign bank_we[gi] = accept & acc_we & (acc_addr == AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q      <= 1'b1;
      win_b_q       <= 1'b0;
      rsp_rdata_a_q <= '0;
      rsp_rdata_b_q <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      if (accept) begin
        last_b_q <= grant_b;
        win_b_q  <= grant_b;
        if (grant_b) rsp_rdata_b_q <= acc_data;
        else         rsp_rdata_a_q <= acc_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (bank_we[i]) bank_q[i] <= acc_wdata;
      end
    end
  end

  assign rsp_rdata_a = rsp_rdata_a_q;
  assign rsp_rdata_b = rsp_rdata_b_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the bank and the round-robin grant.
module tb_reg_bank_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             va, wea, vb, web;
  logic [AW-1:0]    aa, ab;
  logic [WIDTH-1:0] da, db;
  logic             ra, rb, rva, rvb;
  logic [WIDTH-1:0] rda, rdb;

  int checks = 0;
  int passes = 0;

  // Model state: bank contents, who was served last, pending response, held response data.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_last_b, m_busy, m_who_b;
  logic [WIDTH-1:0] m_rd_a, m_rd_b;
  bit               e_ra, e_rb, e_rva, e_rvb;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(va), .req_we_a(wea), .req_addr_a(aa), .req_wdata_a(da),
    .req_ready_a(ra), .rsp_valid_a(rva), .rsp_rdata_a(rda),
    .req_valid_b(vb), .req_we_b(web), .req_addr_b(ab), .req_wdata_b(db),
    .req_ready_b(rb), .rsp_valid_b(rvb), .rsp_rdata_b(rdb)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last_b = 1'b1;
    m_busy   = 1'b0;
    m_who_b  = 1'b0;
    m_rd_a   = '0;
    m_rd_b   = '0;
  endtask

  task automatic set_a(input bit v, input bit we, input int addr, input logic [WIDTH-1:0] d);
    va = v; wea = we; aa = AW'(addr); da = d;
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input logic [WIDTH-1:0] d);
    vb = v; web = we; ab = AW'(addr); db = d;
  endtask

  // Predict this cycle's handshake and response, then move to the sampling point.
  task automatic pre();
    e_rva = m_busy && !m_who_b;
    e_rvb = m_busy && m_who_b;
    e_ra  = 1'b0;
    e_rb  = 1'b0;
    if (!m_busy) begin
      if (va && vb) begin
        e_ra = m_last_b;
        e_rb = !m_last_b;
      end else begin
        e_ra = va;
        e_rb = vb;
      end
    end
    #3;
  endtask

  // Apply the effect of the coming rising edge to the model, then step past it.
  task automatic post();
    bit               wb, we;
    int               ad;
    logic [WIDTH-1:0] wd, d;
    if (!rst_n) begin
      model_reset();
    end else if (e_ra || e_rb) begin
      wb = e_rb;
      we = wb ? web : wea;
      ad = wb ? int'(ab) : int'(aa);
      wd = wb ? db : da;
      d  = we ? wd : m_mem[ad];
      if (we) m_mem[ad] = wd;
      if (wb) m_rd_b = d; else m_rd_a = d;
      m_last_b = wb;
      m_who_b  = wb;
      m_busy   = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_a(0, 0, 0, '0);
    set_b(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rva, rvb} !== 2'b00 || rda !== '0 || rdb !== '0)
      $display("FAIL reset_outputs: rsp_valid_a/b=%b%b rdata_a=%h rdata_b=%h, expected 00 0000 0000",
               rva, rvb, rda, rdb);
    else passes++;
  endtask

  task automatic test_post_reset_read();
    set_a(1, 0, 5, '0);
    pre();
    checks++;
    if ({ra, rb} !== 2'b10) $display("FAIL prr_ready: ready_a/b=%b%b expected 10", ra, rb);
    else passes++;
    post();
    set_a(0, 0, 0, '0);
    pre();
    checks++;
    if ({rva, rvb} !== 2'b10 || rda !== 16'h0000)
      $display("FAIL prr_rsp: rsp_valid_a/b=%b%b rdata_a=%h, expected 10 0000", rva, rvb, rda);
    else passes++;
    post();
  endtask

  task automatic test_cross_port();
    set_a(1, 1, 3, 16'h8285);
    pre(); post();
    set_a(0, 0, 0, '0);
    pre();
    checks++;
    if (rva !== 1'b1 || rda !== 16'h8285)
      $display("FAIL xport_wr_rsp: rsp_valid_a=%b rdata_a=%h, expected 1 8285", rva, rda);
    else passes++;
    post();
    set_b(1, 0, 3, '0);
    pre();
    checks++;
    if ({ra, rb} !== 2'b01) $display("FAIL xport_rd_ready: ready_a/b=%b%b expected 01", ra, rb);
    else passes++;
    post();
    set_b(0, 0, 0, '0);
    pre();
    checks++;
    if ({rva, rvb} !== 2'b01 || rdb !== 16'h8285)
      $display("FAIL xport_rd_rsp: rsp_valid_a/b=%b%b rdata_b=%h, expected 01 8285", rva, rvb, rdb);
    else passes++;
    post();
    set_a(1, 0, 2, '0);
    pre(); post();
    set_a(0, 0, 0, '0);
    pre();
    checks++;
    if (rva !== 1'b1 || rda !== 16'h0000)
      $display("FAIL xport_unused: rsp_valid_a=%b rdata_a=%h, expected 1 0000", rva, rda);
    else passes++;
    post();
  endtask

  task automatic test_first_contention();
    do_reset();
    set_a(1, 1, 1, 16'd1);
    set_b(1, 1, 1, 16'd2);
    pre();
    checks++;
    if ({ra, rb} !== 2'b10) $display("FAIL fc_first: ready_a/b=%b%b expected 10", ra, rb);
    else passes++;
    post();
    set_a(0, 0, 0, '0);
    pre();
    checks++;
    if ({ra, rb, rva, rvb} !== 4'b0010 || rda !== 16'd1)
      $display("FAIL fc_resp_a: ready/rsp=%b rdata_a=%h, expected 0010 0001", {ra, rb, rva, rvb}, rda);
    else passes++;
    post();
    pre();
    checks++;
    if ({ra, rb} !== 2'b01) $display("FAIL fc_second: ready_a/b=%b%b expected 01", ra, rb);
    else passes++;
    post();
    set_b(0, 0, 0, '0);
    pre(); post();
    set_b(1, 0, 1, '0);
    pre(); post();
    set_b(0, 0, 0, '0);
    pre();
    checks++;
    if (rvb !== 1'b1 || rdb !== 16'd2)
      $display("FAIL fc_readback: rsp_valid_b=%b rdata_b=%h, expected 1 0002", rvb, rdb);
    else passes++;
    post();
  endtask

  task automatic test_sustained();
    int left_a = 4, left_b = 4, n_acc = 0, last_cyc = -10;
    bit prev_rva = 0, prev_rvb = 0, acc_a, acc_b;
    set_a(1, 0, int'($urandom_range(0, 7)), '0);
    set_b(1, 0, int'($urandom_range(0, 7)), '0);
    for (int cyc = 0; cyc < 24 && (left_a + left_b > 0 || m_busy); cyc++) begin
      pre();
      checks++;
      if ({ra, rb, rva, rvb} !== {e_ra, e_rb, e_rva, e_rvb})
        $display("FAIL sus_hs cyc %0d: ready/rsp=%b expected %b", cyc, {ra, rb, rva, rvb},
                 {e_ra, e_rb, e_rva, e_rvb});
      else passes++;
      checks++;
      if ((rva && rvb) || (rva && prev_rva) || (rvb && prev_rvb))
        $display("FAIL sus_pulse cyc %0d: rsp_valid_a/b=%b%b prev=%b%b, expected single one-cycle pulses",
                 cyc, rva, rvb, prev_rva, prev_rvb);
      else passes++;
      checks++;
      if (rda !== m_rd_a || rdb !== m_rd_b)
        $display("FAIL sus_data cyc %0d: rdata_a/b=%h/%h expected %h/%h", cyc, rda, rdb, m_rd_a, m_rd_b);
      else passes++;
      acc_a = ra; acc_b = rb;
      if (acc_a || acc_b) begin
        checks++;
        if (acc_a !== (n_acc % 2 == 0))
          $display("FAIL sus_order acc %0d: got %s expected %s", n_acc, acc_a ? "A" : "B",
                   (n_acc % 2 == 0) ? "A" : "B");
        else passes++;
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_cyc != 2)
            $display("FAIL sus_gap acc %0d: %0d cycles since previous accept, expected 2", n_acc, cyc - last_cyc);
          else passes++;
        end
        last_cyc = cyc;
        n_acc++;
      end
      prev_rva = rva; prev_rvb = rvb;
      post();
      if (acc_a) begin
        left_a--;
        if (left_a == 0) va = 1'b0; else aa = AW'($urandom_range(0, 7));
      end
      if (acc_b) begin
        left_b--;
        if (left_b == 0) vb = 1'b0; else ab = AW'($urandom_range(0, 7));
      end
    end
    checks++;
    if (n_acc != 8) $display("FAIL sus_count: %0d accepts, expected 8", n_acc);
    else passes++;
  endtask

  task automatic test_walking();
    logic [WIDTH-1:0] pat;
    for (int k = 0; k < DEPTH; k++) begin
      pat = (k == 7) ? 16'h8000 : 16'(1 << k);
      if (k == 7) set_b(1, 1, k, pat); else set_a(1, 1, k, pat);
      pre(); post();
      set_a(0, 0, 0, '0);
      set_b(0, 0, 0, '0);
      pre(); post();
    end
    for (int k = 0; k < DEPTH; k++) begin
      pat = (k == 7) ? 16'h8000 : 16'(1 << k);
      set_a(1, 0, k, '0);
      pre(); post();
      set_a(0, 0, 0, '0);
      pre();
      checks++;
      if (rva !== 1'b1 || rda !== pat || rda !== m_rd_a)
        $display("FAIL walk_rd addr %0d: rsp_valid_a=%b rdata_a=%h expected 1 %h", k, rva, rda, pat);
      else passes++;
      post();
    end
  endtask

  task automatic test_reset_midop();
    set_a(1, 1, 4, 16'h1234);
    pre();
    checks++;
    if (ra !== 1'b1) $display("FAIL rmid_accept: ready_a=%b expected 1", ra);
    else passes++;
    post();
    set_a(0, 0, 0, '0);
    rst_n = 1'b0;
    pre();
    checks++;
    if (rva !== 1'b1) $display("FAIL rmid_resp_before: rsp_valid_a=%b expected 1", rva);
    else passes++;
    post();
    checks++;
    if ({rva, rvb} !== 2'b00 || rda !== '0)
      $display("FAIL rmid_suppressed: rsp_valid_a/b=%b%b rdata_a=%h expected 00 0000", rva, rvb, rda);
    else passes++;
    rst_n = 1'b1;
    set_a(1, 0, 4, '0);
    set_b(1, 0, 4, '0);
    pre();
    checks++;
    if ({ra, rb} !== 2'b10) $display("FAIL rmid_grant: ready_a/b=%b%b expected 10", ra, rb);
    else passes++;
    post();
    set_a(0, 0, 0, '0);
    pre();
    checks++;
    if (rva !== 1'b1 || rda !== 16'h0000)
      $display("FAIL rmid_lost_write: rsp_valid_a=%b rdata_a=%h expected 1 0000", rva, rda);
    else passes++;
    post();
    pre(); post();
    set_b(0, 0, 0, '0);
    pre();
    checks++;
    if (rvb !== 1'b1 || rdb !== 16'h0000)
      $display("FAIL rmid_b_read: rsp_valid_b=%b rdata_b=%h expected 1 0000", rvb, rdb);
    else passes++;
    post();
  endtask

  task automatic test_random();
    bit acc_a, acc_b;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      pre();
      checks++;
      if ({ra, rb, rva, rvb} !== {e_ra, e_rb, e_rva, e_rvb} || rda !== m_rd_a || rdb !== m_rd_b)
        $display("FAIL rand cyc %0d: ready/rsp=%b rdata=%h/%h expected %b %h/%h", cyc,
                 {ra, rb, rva, rvb}, rda, rdb, {e_ra, e_rb, e_rva, e_rvb}, m_rd_a, m_rd_b);
      else passes++;
      acc_a = e_ra; acc_b = e_rb;
      post();
      if (va && !acc_a) begin
        if ($urandom_range(0, 9) == 0) va = 1'b0;
      end else begin
        set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
      end
      if (vb && !acc_b) begin
        if ($urandom_range(0, 9) == 0) vb = 1'b0;
      end else begin
        set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(0, 0, 0, '0);
    set_b(0, 0, 0, '0);
    test_reset();
    test_post_reset_read();
    test_cross_port();
    test_first_contention();
    test_sustained();
    test_walking();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
